// File: rtl/soc_pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package soc_pll_rst_pkg;

  // Sequencer states; the encoding is visible on state_o for debug.
  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_SETTLE    = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  // Width of a cycle counter that must reach (largest duration - 1).
  function automatic int cyc_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/soc_sync2.sv
// Generic 2-flop synchronizer, synchronous active-high reset to 0.
module soc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; only q may be used by downstream logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc_pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer on the board reference clock.
// Pulses the PLL reset, waits for lock (with timeout), requires a stable
// lock window, then releases the system reset; re-runs on lock loss.
module soc_pll_reset_sequencer
  import soc_pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked_i,
  input  logic             clr_counts,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int CW = cyc_cnt_w(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc;
  logic          locked_s;
  logic          inc_timeout, inc_loss;

  soc_sync2 #(.W(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked_i),
    .q   (locked_s)
  );

  // Next-state and event decode; lock beats timeout in WAIT_LOCK.
  always_comb begin
    state_nxt   = state;
    inc_timeout = 1'b0;
    inc_loss    = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cyc == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_SETTLE;
        end else if (cyc == TIMEOUT_LAST) begin
          state_nxt   = ST_PLL_RST;
          inc_timeout = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!locked_s)               state_nxt = ST_WAIT_LOCK;
        else if (cyc == STABLE_LAST) state_nxt = ST_RUN;
      end
      default: begin
        if (!locked_s) begin
          state_nxt = ST_PLL_RST;
          inc_loss  = 1'b1;
        end
      end
    endcase
  end

  // State, cycle counter and registered reset outputs. The counter clears on
  // every transition and holds in RUN so it never wraps while idle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state   <= ST_PLL_RST;
      cyc     <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
    end else begin
      state   <= state_nxt;
      pll_rst <= (state_nxt == ST_PLL_RST);
      sys_rst <= (state_nxt != ST_RUN);
      if (state_nxt != state)     cyc <= '0;
      else if (state != ST_RUN)   cyc <= cyc + CW'(1);
    end
  end

  // Saturating debug counters; a clear request beats a coincident increment.
  always_ff @(posedge refclk) begin
    if (rst || clr_counts) begin
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      if (inc_loss && lock_loss_cnt != CNT_MAX)  lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      if (inc_timeout && timeout_cnt != CNT_MAX) timeout_cnt   <= timeout_cnt + CNT_W'(1);
    end
  end

  assign ready   = ~sys_rst;
  assign state_o = state;

endmodule

// File: tb/tb_soc_pll_reset_sequencer.sv
// Directed bench for soc_pll_reset_sequencer with a timestamp-based model.
module tb_soc_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int STC = 8;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lk  = 1'b0;
  logic          clr = 1'b0;
  logic          pll_rst, sys_rst, ready;
  logic [1:0]    state_o;
  logic [CW-1:0] lock_loss_cnt, timeout_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  soc_pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(STC), .CNT_W(CW)
  ) dut (
    .refclk(clk), .rst(rst), .pll_locked_i(lk), .clr_counts(clr),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .state_o(state_o),
    .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number, time the phase was entered, edge history of the
  // lock input (locked_s is what was sampled two edges back).
  int   m_ph = 0, m_entry = 0, now = 0;
  int   m_to = 0, m_ll = 0;
  bit   hist[$];
  bit   m_ok = 0;
  int   dur[3] = '{PRC, LTO, STC};

  always @(posedge clk) begin
    int  age;
    bit  ls, leave;
    int  nph;
    now++;
    if (rst) begin
      m_ph = 0; m_entry = now; m_to = 0; m_ll = 0; m_ok = 1;
      hist = '{0, 0};
    end else begin
      ls  = hist[0];
      age = now - 1 - m_entry;
      leave = (m_ph != 3) && (age == dur[m_ph] - 1);
      nph = m_ph;
      if (m_ph == 0 && leave)         nph = 1;
      else if (m_ph == 1 && ls)       nph = 2;
      else if (m_ph == 1 && leave)    nph = 0;
      else if (m_ph == 2 && !ls)      nph = 1;
      else if (m_ph == 2 && leave)    nph = 3;
      else if (m_ph == 3 && !ls)      nph = 0;
      if (clr) begin
        m_to = 0; m_ll = 0;
      end else begin
        if (m_ph == 1 && nph == 0) m_to = (m_to < SAT) ? m_to + 1 : SAT;
        if (m_ph == 3 && nph == 0) m_ll = (m_ll < SAT) ? m_ll + 1 : SAT;
      end
      if (nph != m_ph) m_entry = now;
      m_ph = nph;
      void'(hist.pop_front());
      hist.push_back(lk);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_state", int'(state_o), m_ph);
      chk("m_pll_rst", int'(pll_rst), int'(m_ph == 0));
      chk("m_sys_rst", int'(sys_rst), int'(m_ph != 3));
      chk("m_ready", int'(ready), int'(m_ph == 3));
      chk("m_loss", int'(lock_loss_cnt), m_ll);
      chk("m_timeout", int'(timeout_cnt), m_to);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Clean bring-up with lock already present; now at cycle 0 of PLL_RST.
    rst = 1; lk = 1; clr = 0;
    step(2); rst = 0;
    chk("bring_c0_state", int'(state_o), 0);
    chk("bring_c0_pllrst", int'(pll_rst), 1);
    step(3); chk("bring_c3_pllrst", int'(pll_rst), 1);
    step(1); chk("bring_c4_state", int'(state_o), 1);
    chk("bring_c4_pllrst", int'(pll_rst), 0);
    step(1); chk("bring_c5_state", int'(state_o), 2);
    step(7); chk("bring_c12_ready", int'(ready), 0);
    step(1); chk("bring_c13_ready", int'(ready), 1);
    chk("bring_c13_sysrst", int'(sys_rst), 0);
    chk("bring_counts", int'(lock_loss_cnt) + int'(timeout_cnt), 0);

    // Lock loss in RUN: reset reasserts three edges after the drop.
    lk = 0;
    step(2); chk("loss_e2_ready", int'(ready), 1);
    step(1); chk("loss_e3_pllrst", int'(pll_rst), 1);
    chk("loss_e3_sysrst", int'(sys_rst), 1);
    chk("loss_cnt1", int'(lock_loss_cnt), 1);
    lk = 1;
    step(12); chk("rerun_c12_ready", int'(ready), 0);
    step(1);  chk("rerun_c13_ready", int'(ready), 1);

    // SETTLE glitch: drop again, then relock and glitch during SETTLE.
    lk = 0; step(3); lk = 1;         // PLL_RST cycle 0
    chk("gl_loss_cnt", int'(lock_loss_cnt), 2);
    step(6); chk("gl_c6_state", int'(state_o), 2);
    lk = 0; step(1); lk = 1;         // input low across one edge
    step(1); chk("gl_c8_state", int'(state_o), 2);
    step(1); chk("gl_c9_state", int'(state_o), 1);
    chk("gl_c9_pllrst", int'(pll_rst), 0);
    chk("gl_c9_ready", int'(ready), 0);
    step(8); chk("gl_c17_ready", int'(ready), 0);
    step(1); chk("gl_c18_ready", int'(ready), 1);

    // Clear collides with RUN->PLL_RST increment: clear wins.
    lk = 0; step(2); clr = 1;
    step(1); clr = 0;
    chk("clr_pllrst", int'(pll_rst), 1);
    chk("clr_loss0", int'(lock_loss_cnt), 0);

    // Timeout retry with lock held low; now PLL_RST cycle 0.
    step(4);  chk("to_c4_state", int'(state_o), 1);
    step(19); chk("to_c23_state", int'(state_o), 1);
    chk("to_c23_cnt", int'(timeout_cnt), 0);
    step(1);  chk("to_c24_pllrst", int'(pll_rst), 1);
    chk("to_cnt1", int'(timeout_cnt), 1);
    step(24); chk("to_cnt2", int'(timeout_cnt), 2);
    step(24); chk("to_cnt3", int'(timeout_cnt), 3);
    step(24); chk("to_cnt_sat", int'(timeout_cnt), 3);
    chk("to_c96_pllrst", int'(pll_rst), 1);

    // Recover into SETTLE, then a one-cycle rst mid-SETTLE.
    lk = 1;
    step(6); chk("mid_c6_state", int'(state_o), 2);
    rst = 1; step(1); rst = 0;
    chk("mid_state", int'(state_o), 0);
    chk("mid_pllrst", int'(pll_rst), 1);
    chk("mid_sysrst", int'(sys_rst), 1);
    chk("mid_counts", int'(lock_loss_cnt) + int'(timeout_cnt), 0);
    step(12); chk("post_c12_ready", int'(ready), 0);
    step(1);  chk("post_c13_ready", int'(ready), 1);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
